// File: rtl/axis_pair_multiplier_if.sv
// rtl/axis_pair_multiplier_if.sv - AXI-Stream bundle used for the operand and product ports
//
// Purpose: groups one AXI-Stream channel (valid/data/strobe/last/ready).
// Ports (interface members):
//   TVALID  beat valid (master -> slave)
//   TDATA   beat payload, WIDTH bits (master -> slave)
//   TSTRB   byte strobes, WIDTH/8 bits (master -> slave)
//   TLAST   last beat of packet (master -> slave)
//   TREADY  slave ready (slave -> master)
interface axis_pair_multiplier_if #(
  parameter int WIDTH = 32
) ();
  logic               TVALID;
  logic [WIDTH-1:0]   TDATA;
  logic [WIDTH/8-1:0] TSTRB;
  logic               TLAST;
  logic               TREADY;

  modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/axis_pair_multiplier.sv
// rtl/axis_pair_multiplier.sv - multiplies consecutive AXI-Stream operand pairs into a product stream
//
// Purpose: consumes operand beats as (A, B) pairs and emits A*B per pair through a
// two-stage registered pipeline (P1 operands, P2 product) with full backpressure.
// A TLAST on an A beat closes an odd packet: A is emitted extended to product width.
// Optional feature macro: AXIS_PAIR_MULT_COUNT_EN adds prod_count (saturating count
// of completed product handshakes).
// Ports:
//   AXIS_ACLK    clock for both streams
//   AXIS_ARESET  synchronous active-high reset
//   S_AXIS       operand stream (slave modport), width C_S_AXIS_TDATA_WIDTH
//   M_AXIS       product stream (master modport), width C_M_AXIS_TDATA_WIDTH
//   busy         high while an operand or product is held internally
//   prod_count   [15:0] completed product handshakes (AXIS_PAIR_MULT_COUNT_EN only)
module axis_pair_multiplier #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 64,
  parameter int C_SIGNED             = 0
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESET,
  axis_pair_multiplier_if.slave  S_AXIS,
  axis_pair_multiplier_if.master M_AXIS,
  output logic                   busy
`ifdef AXIS_PAIR_MULT_COUNT_EN
  ,
  output logic [15:0]            prod_count
`endif
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int PW = C_M_AXIS_TDATA_WIDTH;

  generate
    if (PW != 2 * W) begin : g_width_check
      $error("C_M_AXIS_TDATA_WIDTH must be twice C_S_AXIS_TDATA_WIDTH");
    end
  endgenerate

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic            p1_v_q, p1_v_d;
  logic [W-1:0]    p1_a_q, p1_a_d;
  logic [W-1:0]    p1_b_q, p1_b_d;
  logic            p1_last_q, p1_last_d;
  logic            p2_v_q, p2_v_d;
  logic [PW-1:0]   p2_data_q, p2_data_d;
  logic            p2_last_q, p2_last_d;

  logic            p2_load;
  logic            p1_load;
  logic            s_ready;
  logic            s_accept;
  logic            p1_take;
  logic [PW-1:0]   op_a_ext;
  logic [PW-1:0]   op_b_ext;
  logic [PW-1:0]   product;

  // Strobes carry no meaning for an arithmetic stream.
  logic            unused_tstrb;
  assign unused_tstrb = ^S_AXIS.TSTRB;

`ifdef AXIS_PAIR_MULT_COUNT_EN
  logic [15:0]     prod_count_q, prod_count_d;
`endif

  always_comb begin
    p2_load = !p2_v_q || M_AXIS.TREADY;
    p1_load = !p1_v_q || p2_load;

    // An A beat with TLAST goes straight into P1, so it must wait for a free slot;
    // an ordinary A beat only lands in a_q and is always accepted.
    if (state_q == WAIT_A) begin
      s_ready = S_AXIS.TLAST ? p1_load : 1'b1;
    end else begin
      s_ready = p1_load;
    end
    if (AXIS_ARESET) begin
      s_ready = 1'b0;
    end

    s_accept = S_AXIS.TVALID && s_ready;
    p1_take  = s_accept && ((state_q == WAIT_B) || S_AXIS.TLAST);

    // Extending both operands to the product width and keeping the low PW bits of
    // the product gives the correct two's-complement result in the signed case.
    if (C_SIGNED != 0) begin
      op_a_ext = {{(PW - W){p1_a_q[W-1]}}, p1_a_q};
      op_b_ext = {{(PW - W){p1_b_q[W-1]}}, p1_b_q};
    end else begin
      op_a_ext = {{(PW - W){1'b0}}, p1_a_q};
      op_b_ext = {{(PW - W){1'b0}}, p1_b_q};
    end
    product = op_a_ext * op_b_ext;

    state_d   = state_q;
    a_d       = a_q;
    p1_v_d    = p1_v_q;
    p1_a_d    = p1_a_q;
    p1_b_d    = p1_b_q;
    p1_last_d = p1_last_q;
    p2_v_d    = p2_v_q;
    p2_data_d = p2_data_q;
    p2_last_d = p2_last_q;

    if (s_accept) begin
      if (state_q == WAIT_A) begin
        a_d     = S_AXIS.TDATA;
        state_d = S_AXIS.TLAST ? WAIT_A : WAIT_B;
      end else begin
        state_d = WAIT_A;
      end
    end

    // P2 refills from P1 whenever it is free or being drained this cycle; if P1 is
    // empty at that moment the output valid drops but the data is left as is.
    if (p2_load) begin
      p2_v_d = p1_v_q;
      if (p1_v_q) begin
        p2_data_d = product;
        p2_last_d = p1_last_q;
      end
      p1_v_d = 1'b0;
    end

    if (p1_take) begin
      p1_v_d    = 1'b1;
      p1_last_d = S_AXIS.TLAST;
      if (state_q == WAIT_B) begin
        p1_a_d = a_q;
        p1_b_d = S_AXIS.TDATA;
      end else begin
        // Odd packet: multiply by one so the lone operand passes through extended.
        p1_a_d = S_AXIS.TDATA;
        p1_b_d = {{(W - 1){1'b0}}, 1'b1};
      end
    end

`ifdef AXIS_PAIR_MULT_COUNT_EN
    prod_count_d = prod_count_q;
    if (p2_v_q && M_AXIS.TREADY && (prod_count_q != 16'hFFFF)) begin
      prod_count_d = prod_count_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q      <= WAIT_A;
      a_q          <= '0;
      p1_v_q       <= 1'b0;
      p1_a_q       <= '0;
      p1_b_q       <= '0;
      p1_last_q    <= 1'b0;
      p2_v_q       <= 1'b0;
      p2_data_q    <= '0;
      p2_last_q    <= 1'b0;
`ifdef AXIS_PAIR_MULT_COUNT_EN
      prod_count_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      p1_v_q       <= p1_v_d;
      p1_a_q       <= p1_a_d;
      p1_b_q       <= p1_b_d;
      p1_last_q    <= p1_last_d;
      p2_v_q       <= p2_v_d;
      p2_data_q    <= p2_data_d;
      p2_last_q    <= p2_last_d;
`ifdef AXIS_PAIR_MULT_COUNT_EN
      prod_count_q <= prod_count_d;
`endif
    end
  end

  assign S_AXIS.TREADY = s_ready;
  assign M_AXIS.TVALID = p2_v_q;
  assign M_AXIS.TDATA  = p2_data_q;
  assign M_AXIS.TLAST  = p2_last_q;
  assign M_AXIS.TSTRB  = '1;
  assign busy          = (state_q == WAIT_B) || p1_v_q || p2_v_q;

`ifdef AXIS_PAIR_MULT_COUNT_EN
  assign prod_count = prod_count_q;
`endif

endmodule
